uart_tx: RTL and testbench

- UART serializer that sits directly downstream of the UART AXI-lite controller.
- Consumes the controller's tx_enable/tx_data/config outputs and drives the serial line with a start bit, data bits (LSB first), optional parity and stop bit(s).
- Returns start/data/tx completion pulses for the controller's status register.
- Contains its own baud-tick counter; no external baud strobe.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and the config bit
// meanings agreed with the AXI-lite controller.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    localparam logic DATA_BITS_SHORT = 1'b0;  // DATA_WIDTH-1 data bits
    localparam logic DATA_BITS_FULL  = 1'b1;  // DATA_WIDTH data bits
    localparam logic STOP_BITS_ONE   = 1'b0;
    localparam logic STOP_BITS_TWO   = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Per-bit clock counter: counts 0..N-1 and flags the last clock of each bit.
// A divider value of 0 behaves like 1 (bit_end every clock).
module uart_baud_gen #(
    parameter int unsigned BAUD_VALUE_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        a_rst_n_i,
    input  logic                        clear_i,
    input  logic [BAUD_VALUE_WIDTH-1:0] baud_val_i,
    output logic                        bit_end_c
);

    localparam int unsigned W = BAUD_VALUE_WIDTH;

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] last_c;

    always_comb begin
        last_c    = (baud_val_i == '0) ? '0 : baud_val_i - W'(1);
        bit_end_c = (cnt_q == last_c);
        cnt_d     = cnt_q + W'(1);
        if (clear_i || bit_end_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART serializer: start bit, LSB-first data, optional even parity, 1/2 stop bits.
// Build with UART_TX_PARITY_EN defined to insert the parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned BAUD_VALUE_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        a_rst_n_i,
    input  logic                        tx_enable_i,
    input  logic [DATA_WIDTH-1:0]       tx_data_i,
    input  logic                        data_bit_num_i,
    input  logic                        stop_bit_num_i,
    input  logic [BAUD_VALUE_WIDTH-1:0] baud_tick_val_i,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic                        start_complete_o,
    output logic                        data_complete_o,
    output logic                        tx_complete_o
);

    localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);

    uart_state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]       shift_q, shift_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        data_bit_num_q, data_bit_num_d;
    logic                        stop_bit_num_q, stop_bit_num_d;
    logic [BAUD_VALUE_WIDTH-1:0] baud_q, baud_d;
    logic                        tx_q, tx_d;
    logic                        busy_q, busy_d;
    logic                        start_complete_q, start_complete_d;
    logic                        data_complete_q, data_complete_d;
    logic                        tx_complete_q, tx_complete_d;
    logic                        bit_end_c;
    logic [IDX_W-1:0]            last_idx_c;
`ifdef UART_TX_PARITY_EN
    logic                        parity_q, parity_d;
    logic [DATA_WIDTH-1:0]       payload_c;
`endif

    uart_baud_gen #(
        .BAUD_VALUE_WIDTH(BAUD_VALUE_WIDTH)
    ) u_baud_gen (
        .clk_i     (clk_i),
        .a_rst_n_i (a_rst_n_i),
        .clear_i   (state_q == ST_IDLE),
        .baud_val_i(baud_q),
        .bit_end_c (bit_end_c)
    );

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d          = state_q;
        shift_d          = shift_q;
        idx_d            = idx_q;
        data_bit_num_d   = data_bit_num_q;
        stop_bit_num_d   = stop_bit_num_q;
        baud_d           = baud_q;
        start_complete_d = 1'b0;
        data_complete_d  = 1'b0;
        tx_complete_d    = 1'b0;
        last_idx_c       = (data_bit_num_q == DATA_BITS_FULL) ? IDX_W'(DATA_WIDTH - 1)
                                                               : IDX_W'(DATA_WIDTH - 2);
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
        payload_c = (data_bit_num_i == DATA_BITS_FULL) ? tx_data_i
                                                       : {1'b0, tx_data_i[DATA_WIDTH-2:0]};
`endif

        case (state_q)
            ST_IDLE: begin
                if (tx_enable_i) begin
                    state_d        = ST_START;
                    shift_d        = tx_data_i;
                    idx_d          = '0;
                    data_bit_num_d = data_bit_num_i;
                    stop_bit_num_d = stop_bit_num_i;
                    baud_d         = baud_tick_val_i;
`ifdef UART_TX_PARITY_EN
                    parity_d       = ^payload_c;
`endif
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    state_d          = ST_DATA;
                    idx_d            = '0;
                    start_complete_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == last_idx_c) begin
                        data_complete_d = 1'b1;
                        idx_d           = '0;
`ifdef UART_TX_PARITY_EN
                        state_d         = ST_PARITY;
`else
                        state_d         = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_c) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_c) begin
                    if (stop_bit_num_q == STOP_BITS_TWO && idx_q == '0) begin
                        idx_d = IDX_W'(1);
                    end else begin
                        state_d       = ST_IDLE;
                        tx_complete_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx_o is registered
        case (state_d)
            ST_START: tx_d = START_BIT;
            ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = LINE_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_q          <= ST_IDLE;
            shift_q          <= '0;
            idx_q            <= '0;
            data_bit_num_q   <= DATA_BITS_SHORT;
            stop_bit_num_q   <= STOP_BITS_ONE;
            baud_q           <= '0;
            tx_q             <= LINE_IDLE;
            busy_q           <= 1'b0;
            start_complete_q <= 1'b0;
            data_complete_q  <= 1'b0;
            tx_complete_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q         <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            shift_q          <= shift_d;
            idx_q            <= idx_d;
            data_bit_num_q   <= data_bit_num_d;
            stop_bit_num_q   <= stop_bit_num_d;
            baud_q           <= baud_d;
            tx_q             <= tx_d;
            busy_q           <= busy_d;
            start_complete_q <= start_complete_d;
            data_complete_q  <= data_complete_d;
            tx_complete_q    <= tx_complete_d;
`ifdef UART_TX_PARITY_EN
            parity_q         <= parity_d;
`endif
        end
    end

    assign tx_o             = tx_q;
    assign busy_o           = busy_q;
    assign start_complete_o = start_complete_q;
    assign data_complete_o  = data_complete_q;
    assign tx_complete_o    = tx_complete_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: each frame is checked clock by clock against a
// bit-timeline model built from the frame's configuration.
module tb_uart_tx;

    localparam int unsigned DW = 8;
    localparam int unsigned BW = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic          clk = 1'b0;
    logic          a_rst_n;
    logic          tx_enable;
    logic [DW-1:0] tx_data;
    logic          data_bit_num;
    logic          stop_bit_num;
    logic [BW-1:0] baud_tick_val;
    logic          tx_o, busy_o, start_complete_o, data_complete_o, tx_complete_o;

    uart_tx #(.DATA_WIDTH(DW), .BAUD_VALUE_WIDTH(BW)) dut (
        .clk_i           (clk),
        .a_rst_n_i       (a_rst_n),
        .tx_enable_i     (tx_enable),
        .tx_data_i       (tx_data),
        .data_bit_num_i  (data_bit_num),
        .stop_bit_num_i  (stop_bit_num),
        .baud_tick_val_i (baud_tick_val),
        .tx_o            (tx_o),
        .busy_o          (busy_o),
        .start_complete_o(start_complete_o),
        .data_complete_o (data_complete_o),
        .tx_complete_o   (tx_complete_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          dbn;
        logic          sbn;
        logic [BW-1:0] baud;
        bit            chain;  // keep tx_enable high so the next frame follows directly
    } frame_t;

    frame_t      frames[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed outputs packed as {tx, busy, start_complete, data_complete, tx_complete}
    function automatic logic [4:0] obs();
        return {tx_o, busy_o, start_complete_o, data_complete_o, tx_complete_o};
    endfunction

    function automatic int bit_clks(input frame_t f);
        return (f.baud == '0) ? 1 : int'(f.baud);
    endfunction

    function automatic int n_data(input frame_t f);
        return f.dbn ? int'(DW) : int'(DW) - 1;
    endfunction

    function automatic int frame_len(input frame_t f);
        return bit_clks(f) * (1 + n_data(f) + PAR_BITS + (f.sbn ? 2 : 1));
    endfunction

    // Expected outputs k clocks after the capturing edge
    function automatic logic [4:0] exp_at(input frame_t f, input int k);
        int   n, nd, len, b;
        logic t, par;
        n   = bit_clks(f);
        nd  = n_data(f);
        len = frame_len(f);
        par = 1'b0;
        for (int i = 0; i < nd; i++) par = par ^ f.data[i];
        b = k / n;
        if (k >= len)                          t = 1'b1;
        else if (b == 0)                       t = 1'b0;
        else if (b <= nd)                      t = f.data[b-1];
        else if (PAR_BITS == 1 && b == nd + 1) t = par;
        else                                   t = 1'b1;
        return {t, k < len, k == n, k == n * (1 + nd), k == len};
    endfunction

    task automatic drive(input frame_t f, input logic en);
        tx_enable     = en;
        tx_data       = f.data;
        data_bit_num  = f.dbn;
        stop_bit_num  = f.sbn;
        baud_tick_val = f.baud;
    endtask

    task automatic drive_junk();
        tx_enable     = 1'b0;
        tx_data       = DW'($urandom);
        data_bit_num  = 1'($urandom_range(0, 1));
        stop_bit_num  = 1'($urandom_range(0, 1));
        baud_tick_val = BW'($urandom_range(0, 20));
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check(tag, 32'(obs()), 32'(5'b10000));
        end
    endtask

    // Frame f was presented before this call; next is what follows it
    task automatic run_frame(input int id, input frame_t f, input bit has_next, input frame_t next);
        int len;
        len = frame_len(f);
        @(posedge clk);
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            check($sformatf("frame%0d_clk%0d", id, k), 32'(obs()), 32'(exp_at(f, k)));
            if (k == 0) begin
                if (has_next && f.chain) drive(next, 1'b1);
                else                     drive_junk();
            end
        end
        if (has_next && !f.chain) begin
            check_idle($sformatf("gap%0d", id), 2);
            drive(next, 1'b1);
        end
    endtask

    task automatic add(input logic [DW-1:0] d, input logic dbn, input logic sbn,
                       input logic [BW-1:0] baud, input bit chain);
        frame_t f;
        f.data = d; f.dbn = dbn; f.sbn = sbn; f.baud = baud; f.chain = chain;
        frames.push_back(f);
    endtask

    initial begin
        frame_t rf, dummy;

        a_rst_n = 1'b0;
        drive_junk();
        check_idle("reset", 3);
        @(negedge clk);
        a_rst_n = 1'b1;
        check_idle("post_reset", 2);

        // Abort in the middle of the data bits
        rf.data = 8'h0F; rf.dbn = 1'b1; rf.sbn = 1'b0; rf.baud = 16'd8; rf.chain = 1'b0;
        drive(rf, 1'b1);
        @(posedge clk);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("abort_clk%0d", k), 32'(obs()), 32'(exp_at(rf, k)));
            if (k == 0) drive_junk();
        end
        a_rst_n = 1'b0;
        #1;
        check("abort_immediate", 32'({tx_o, busy_o}), 32'(2'b10));
        check_idle("abort_in_reset", 3);
        a_rst_n = 1'b1;
        check_idle("abort_released", 4);

        add(8'hA5, 1'b1, 1'b0, 16'd4, 1'b0);
        add(8'hFF, 1'b0, 1'b1, 16'd2, 1'b0);
        add(8'h00, 1'b1, 1'b0, 16'd3, 1'b1);
        add(8'h55, 1'b1, 1'b0, 16'd3, 1'b0);
        add(8'h81, 1'b1, 1'b0, 16'd0, 1'b0);
        add(8'h07, 1'b1, 1'b0, 16'd2, 1'b0);
        add(8'h0F, 1'b1, 1'b0, 16'd8, 1'b0);
        add(8'h80, 1'b0, 1'b0, 16'd1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            add(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                BW'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));
        end
        frames[frames.size()-1].chain = 1'b0;

        @(negedge clk);
        drive(frames[0], 1'b1);
        dummy = frames[0];
        for (int i = 0; i < frames.size(); i++) begin
            if (i + 1 < frames.size()) run_frame(i, frames[i], 1'b1, frames[i+1]);
            else                       run_frame(i, frames[i], 1'b0, dummy);
        end
        check_idle("final_idle", 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
